// File: rtl/types_pkg.sv
// Shared arbiter types: FSM state and transaction owner encodings.
package types_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_RESP = 1'b1} arb_state_t;
  typedef enum logic [0:0] {OWN_IF = 1'b0, OWN_D = 1'b1} arb_owner_t;
endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one single-outstanding memory port.
// Optional fetch anti-starvation counter enabled by defining ARB_FAIRNESS_EN.
module mem_arbiter
  import types_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  logic       idle, sel_d, grant, fetch_first;

  assign idle = rst_n && (state_q == IDLE);

`ifdef ARB_FAIRNESS_EN
  logic [3:0] starve_q, starve_d;

  // Fetch overrides data priority once it has waited out LIMIT data grants.
  assign fetch_first = if_req && (starve_q >= LIMIT);

  always_comb begin
    starve_d = starve_q;
    if (if_gnt)
      starve_d = '0;
    else if (d_gnt && if_req && (starve_q < LIMIT))
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^LIMIT;
  assign fetch_first = 1'b0;
`endif

  assign sel_d = d_req && !fetch_first;

  always_comb begin
    mem_req   = idle && (if_req || d_req);
    mem_we    = 1'b0;
    mem_be    = 4'hF;
    mem_addr  = if_addr;
    mem_wdata = '0;
    if (sel_d) begin
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  assign grant  = mem_req && mem_ready;
  assign d_gnt  = grant && sel_d;
  assign if_gnt = grant && !sel_d;

  // A response is only meaningful while a transaction is outstanding.
  assign if_rvalid = rst_n && (state_q == WAIT_RESP) && mem_rvalid && (owner_q == OWN_IF);
  assign d_rvalid  = rst_n && (state_q == WAIT_RESP) && mem_rvalid && (owner_q == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = WAIT_RESP;
        owner_d = sel_d ? OWN_D : OWN_IF;
      end
      WAIT_RESP: if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; fairness expectations follow ARB_FAIRNESS_EN.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  // Inputs change on the falling edge; checks run 1 time unit later.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0;
    d_be = 4'hF; d_addr = 32'h0; d_wdata = 32'h0;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0;
    @(negedge clk); step();
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    total++; if ({if_gnt, d_gnt} !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", {if_gnt, d_gnt}); end
    total++; if ({if_rvalid, d_rvalid} !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b exp=00", {if_rvalid, d_rvalid}); end
    if_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
    step(); #1;
    // Stray response in IDLE must be ignored
    total++; if ({if_rvalid, d_rvalid} !== 2'b00) begin bad++; $display("FAIL idle_rvalid_ignored got=%b exp=00", {if_rvalid, d_rvalid}); end
    mem_rvalid = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1;
    #1;
    total++; if ({mem_req, mem_we, mem_be} !== 6'b1_0_1111) begin bad++; $display("FAIL fetch_req got=%b exp=101111", {mem_req, mem_we, mem_be}); end
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL fetch_addr got=%h exp=00000100", mem_addr); end
    total++; if ({if_gnt, d_gnt} !== 2'b10) begin bad++; $display("FAIL fetch_gnt got=%b exp=10", {if_gnt, d_gnt}); end
    step(); if_req = 1'b0; #1;
    total++; if ({mem_req, if_gnt, if_rvalid} !== 3'b000) begin bad++; $display("FAIL fetch_wait got=%b exp=000", {mem_req, if_gnt, if_rvalid}); end
    mem_rvalid = 1'b1; mem_rdata = 32'h00500093; #1;
    total++; if ({if_rvalid, d_rvalid} !== 2'b10) begin bad++; $display("FAIL fetch_rvalid got=%b exp=10", {if_rvalid, d_rvalid}); end
    total++; if (if_rdata !== 32'h00500093) begin bad++; $display("FAIL fetch_rdata got=%h exp=00500093", if_rdata); end
    step(); mem_rvalid = 1'b0; #1;
    total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_rvalid_done got=%b exp=0", if_rvalid); end
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
    #1;
    total++; if ({if_gnt, d_gnt} !== 2'b01) begin bad++; $display("FAIL prio_gnt got=%b exp=01", {if_gnt, d_gnt}); end
    total++; if ({mem_we, mem_addr} !== {1'b1, 32'h200}) begin bad++; $display("FAIL prio_payload got=%b/%h exp=1/00000200", mem_we, mem_addr); end
    total++; if (mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL prio_wdata got=%h exp=deadbeef", mem_wdata); end
    step(); d_req = 1'b0; mem_rvalid = 1'b1; #1;
    total++; if ({if_gnt, mem_req, d_rvalid, if_rvalid} !== 4'b0010) begin bad++; $display("FAIL prio_ack got=%b exp=0010", {if_gnt, mem_req, d_rvalid, if_rvalid}); end
    step(); mem_rvalid = 1'b0; #1;
    total++; if ({if_gnt, d_gnt, mem_addr} !== {2'b10, 32'h100}) begin bad++; $display("FAIL prio_fetch_next got=%b/%h exp=10/00000100", {if_gnt, d_gnt}, mem_addr); end
    step(); if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678; #1;
    total++; if ({if_rvalid, d_rvalid, if_rdata} !== {2'b10, 32'h12345678}) begin bad++; $display("FAIL prio_fetch_resp got=%b/%h exp=10/12345678", {if_rvalid, d_rvalid}, if_rdata); end
    step(); mem_rvalid = 1'b0;
  endtask

  task automatic test_stall();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h340; d_be = 4'h3; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({mem_req, d_gnt, mem_addr, mem_be} !== {2'b10, 32'h340, 4'h3}) begin
        bad++; $display("FAIL stall_hold%0d got=%b/%h/%h exp=10/00000340/3", i, {mem_req, d_gnt}, mem_addr, mem_be);
      end
      step();
    end
    mem_ready = 1'b1; #1;
    total++; if ({mem_req, d_gnt} !== 2'b11) begin bad++; $display("FAIL stall_release got=%b exp=11", {mem_req, d_gnt}); end
    step(); d_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0001; #1;
    total++; if ({d_rvalid, d_rdata} !== {1'b1, 32'hA5A5_0001}) begin bad++; $display("FAIL stall_resp got=%b/%h exp=1/a5a50001", d_rvalid, d_rdata); end
    step(); mem_rvalid = 1'b0;
  endtask

  task automatic test_fairness();
    logic exp_if;
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_FAIRNESS_EN
      exp_if = (k % 5) == 4;
`else
      exp_if = 1'b0;
`endif
      #1;
      total++; if ({if_gnt, d_gnt} !== {exp_if, ~exp_if}) begin
        bad++; $display("FAIL fair_gnt%0d got=%b exp=%b", k, {if_gnt, d_gnt}, {exp_if, ~exp_if});
      end
      step(); mem_rvalid = 1'b1; #1;
      total++; if ({if_rvalid, d_rvalid} !== {exp_if, ~exp_if}) begin
        bad++; $display("FAIL fair_rvalid%0d got=%b exp=%b", k, {if_rvalid, d_rvalid}, {exp_if, ~exp_if});
      end
      step(); mem_rvalid = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
    step();
  endtask

  task automatic test_reset_in_wait();
    if_req = 1'b1; if_addr = 32'h180; mem_ready = 1'b1; #1;
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL rstwait_gnt got=%b exp=1", if_gnt); end
    step(); if_req = 1'b0; rst_n = 1'b0;
    step(); rst_n = 1'b1; mem_rvalid = 1'b1; #1;
    total++; if ({if_rvalid, d_rvalid} !== 2'b00) begin bad++; $display("FAIL rstwait_late_resp got=%b exp=00", {if_rvalid, d_rvalid}); end
    step(); mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h1C0; #1;
    total++; if ({if_gnt, mem_addr} !== {1'b1, 32'h1C0}) begin bad++; $display("FAIL rstwait_regrant got=%b/%h exp=1/000001c0", if_gnt, mem_addr); end
    step(); if_req = 1'b0; mem_rvalid = 1'b1; #1;
    total++; if (if_rvalid !== 1'b1) begin bad++; $display("FAIL rstwait_resp got=%b exp=1", if_rvalid); end
    step(); mem_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_stall();
    test_fairness();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
